// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff chain loader.
//   ccff_state_e : loader FSM states
//   cnt_w(n)     : width of a counter that must hold values 0..n
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Bitstream word serializer: latches one word and presents it LSB first.
//   clk, rst : clock, async active-high reset
//   load     : latch din, reload bit counter with WORD_W
//   step     : one bit consumed this cycle (counter decrements)
//   shift    : move the next bit into the LSB position
//   din      : word to latch
//   lsb      : current bit (registered)
//   bit_cnt  : bits of the latched word not yet consumed
// step and shift are separate so the last consumed bit can stay on lsb
// after the loader stops shifting.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      step,
  input  logic                      shift,
  input  logic [WORD_W-1:0]         din,
  output logic                      lsb,
  output logic [cnt_w(WORD_W)-1:0]  bit_cnt
);

  localparam int BC_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      word_q  <= din;
      bit_cnt <= BC_W'(WORD_W);
    end else begin
      if (shift) word_q  <= word_q >> 1;
      if (step)  bit_cnt <= bit_cnt - BC_W'(1);
    end
  end

  assign lsb = word_q[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration bitstream into a serial ccff chain.
//   prog_clk, pReset      : clock, async active-high reset
//   start                 : begin a load (honoured only in IDLE)
//   abort                 : drop an in-progress load (FETCH/SHIFT)
//   word_valid/word_data  : bitstream word source, LSB shifted first
//   word_ready            : word accepted this cycle (FETCH and no abort)
//   ccff_head             : serial data into the chain head
//   config_enable         : chain shift enable, one bit per high cycle
//   busy, done            : not-IDLE flag, one-cycle completion pulse
//   bits_left             : chain bits still to be shifted
// All outputs except word_ready are registered; they are computed from the
// next state so they line up with the state they describe.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int WORD_W    = 8
) (
  input  logic                         prog_clk,
  input  logic                         pReset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         word_valid,
  input  logic [WORD_W-1:0]            word_data,
  output logic                         word_ready,
  output logic                         ccff_head,
  output logic                         config_enable,
  output logic                         busy,
  output logic                         done,
  output logic [cnt_w(CHAIN_LEN)-1:0]  bits_left
);

  localparam int BL_W = cnt_w(CHAIN_LEN);
  localparam int BC_W = cnt_w(WORD_W);

  ccff_state_e      state_q, state_d;
  logic [BL_W-1:0]  bl_d;
  logic [BC_W-1:0]  bit_cnt;
  logic             ld, step, shift;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk     (prog_clk),
    .rst     (pReset),
    .load    (ld),
    .step    (step),
    .shift   (shift),
    .din     (word_data),
    .lsb     (ccff_head),
    .bit_cnt (bit_cnt)
  );

  assign word_ready = (state_q == ST_FETCH) && !abort;

  always_comb begin
    state_d = state_q;
    bl_d    = bits_left;
    ld      = 1'b0;
    step    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          bl_d    = BL_W'(CHAIN_LEN);
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (word_valid) begin
          ld      = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          bl_d = bits_left - BL_W'(1);
          // chain full wins over word exhaustion; leftover word bits drop
          if (bits_left == BL_W'(1))      state_d = ST_DONE;
          else if (bit_cnt == BC_W'(1))   state_d = ST_FETCH;
          else begin
            state_d = ST_SHIFT;
            shift   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q       <= ST_IDLE;
      bits_left     <= '0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_left     <= bl_d;
      config_enable <= (state_d == ST_SHIFT);
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  localparam int CL   = 12;
  localparam int WW   = 8;
  localparam int BL_W = $clog2(CL + 1);

  logic            prog_clk = 1'b0;
  logic            pReset;
  logic            start, abort, word_valid;
  logic [WW-1:0]   word_data;
  logic            word_ready, ccff_head, config_enable, busy, done;
  logic [BL_W-1:0] bits_left;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .word_ready    (word_ready),
    .ccff_head     (ccff_head),
    .config_enable (config_enable),
    .busy          (busy),
    .done          (done),
    .bits_left     (bits_left)
  );

  always #5 prog_clk = ~prog_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A load is "active" until the chain is full or it is dropped. While
  // active, the queue holds the unshifted bits of the current word; an empty
  // queue means the loader is waiting for a word.
  bit m_active, m_done, m_head;
  int m_bl;
  bit m_q[$];

  task automatic model_reset();
    m_active = 0; m_done = 0; m_head = 0; m_bl = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit nd, dummy;
    nd = 0;
    if (!m_active) begin
      if (!m_done && start) begin
        m_active = 1;
        m_bl = CL;
      end
    end else if (abort) begin
      m_active = 0;
      m_q.delete();
    end else if (m_q.size() == 0) begin
      if (word_valid) begin
        for (int i = 0; i < WW; i++) m_q.push_back(word_data[i]);
        m_head = m_q[0];
      end
    end else begin
      dummy = m_q.pop_front();
      m_bl--;
      if (m_bl == 0) begin
        m_active = 0;
        m_q.delete();
        nd = 1;
      end else if (m_q.size() > 0) begin
        m_head = m_q[0];
      end
    end
    m_done = nd;
  endtask

  // ---------------- per-cycle compare + logging ----------------
  int cyc = 0, en_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int first_en_cyc = 0, done_cyc = 0, start_cyc = 0;
  bit head_log[$];

  initial forever begin
    @(negedge prog_clk);
    cyc++;
    check("config_enable", int'(config_enable), int'(m_active && m_q.size() > 0));
    check("ccff_head", int'(ccff_head), int'(m_head));
    check("busy", int'(busy), int'(m_active || m_done));
    check("done", int'(done), int'(m_done));
    check("bits_left", int'(bits_left), m_bl);
    check("word_ready", int'(word_ready), int'(m_active && m_q.size() == 0 && !abort));
    if (config_enable) begin
      if (en_cnt == 0) first_en_cyc = cyc;
      head_log.push_back(ccff_head);
      en_cnt++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (word_valid && word_ready) acc_cnt++;
    if (start && !busy) start_cyc = cyc;
  end

  task automatic clear_logs();
    en_cnt = 0; done_cnt = 0; acc_cnt = 0;
    head_log.delete();
  endtask

  function automatic logic [CL-1:0] packh();
    logic [CL-1:0] v;
    v = '0;
    for (int i = 0; i < CL && i < head_log.size(); i++) v[i] = head_log[i];
    return v;
  endfunction

  // ---------------- stimulus ----------------
  bit rnd = 0;
  bit hs;
  logic [WW-1:0] feed_q[$];

  task automatic drive_feed();
    word_valid = (feed_q.size() > 0);
    word_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
  endtask

  task automatic tick();
    @(negedge prog_clk);
    hs = word_valid && word_ready;
    @(posedge prog_clk);
    model_step();
    #1;
    if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
    start = 0;
    abort = 0;
    if (rnd) begin
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      word_valid = ($urandom_range(0, 3) != 0);
      word_data  = WW'($urandom);
    end else begin
      drive_feed();
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check({nm, "_done_seen"}, done_cnt, 1);
    tick();
    tick();
  endtask

  task automatic begin_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    clear_logs();
    feed_q.delete();
    feed_q.push_back(w0);
    feed_q.push_back(w1);
    drive_feed();
    start = 1;
  endtask

  initial begin
    model_reset();
    pReset = 1; start = 0; abort = 0; word_valid = 0; word_data = '0;
    repeat (2) @(posedge prog_clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_bits_left", int'(bits_left), 0);
    check("rst_head", int'(ccff_head), 0);
    pReset = 0;
    tick();

    // two words 0x0F, 0x03: 8 bits, one fetch gap, 4 bits, upper bits dropped
    begin_load(8'h0F, 8'h03);
    wait_done("two_word", 60);
    check("two_word_enables", en_cnt, 12);
    check("two_word_heads", int'(packh()), 12'h30F);
    check("two_word_latency", first_en_cyc - start_cyc, 2);
    check("two_word_span", done_cyc - first_en_cyc, 13);
    check("two_word_accepts", acc_cnt, 2);
    check("two_word_pulses", done_cnt, 1);

    // source stalls before the second word
    clear_logs();
    feed_q.delete();
    feed_q.push_back(8'h5A);
    drive_feed();
    start = 1;
    for (int i = 0; i < 40 && en_cnt < 8; i++) tick();
    repeat (5) tick();
    check("stall_bits_left", int'(bits_left), 4);
    check("stall_enable", int'(config_enable), 0);
    check("stall_enables_so_far", en_cnt, 8);
    feed_q.push_back(8'hC3);
    drive_feed();
    wait_done("stall", 40);
    check("stall_enables", en_cnt, 12);
    check("stall_heads", int'(packh()), 12'h35A);

    // abort with 2 bits left, then a full load
    begin_load(8'hFF, 8'hFF);
    for (int i = 0; i < 60 && !(config_enable && bits_left == 2); i++) tick();
    check("abort_reached", int'(bits_left), 2);
    abort = 1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_enable", int'(config_enable), 0);
    repeat (3) tick();
    check("abort_no_done", done_cnt, 0);
    begin_load(8'h12, 8'h34);
    wait_done("after_abort", 60);
    check("after_abort_enables", en_cnt, 12);
    check("after_abort_heads", int'(packh()), 12'h412);

    // start while busy is ignored
    begin_load(8'h96, 8'h69);
    for (int i = 0; i < 40 && en_cnt < 3; i++) tick();
    start = 1;
    tick();
    wait_done("busy_start", 60);
    repeat (4) tick();
    check("busy_start_pulses", done_cnt, 1);
    check("busy_start_enables", en_cnt, 12);
    check("busy_start_idle", int'(busy), 0);

    // asynchronous reset in the middle of shifting
    begin_load(8'hFF, 8'hFF);
    for (int i = 0; i < 40 && en_cnt < 3; i++) tick();
    #1 pReset = 1;
    model_reset();
    #1;
    check("arst_enable", int'(config_enable), 0);
    check("arst_head", int'(ccff_head), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_bits_left", int'(bits_left), 0);
    #1 pReset = 0;
    feed_q.delete();
    drive_feed();
    repeat (4) tick();
    check("arst_stays_idle", int'(busy), 0);
    begin_load(8'hA5, 8'h0C);
    wait_done("post_rst", 60);
    check("post_rst_heads", int'(packh()), 12'hCA5);

    // randomized traffic against the model
    rnd = 1;
    repeat (3000) tick();
    rnd = 0;
    feed_q.delete();
    abort = 1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
